mod_counter: RTL
================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter width in bits (1..32).
REQ-002 The block SHALL have parameter MOD, default 16, count modulus (2..2**WIDTH).
REQ-003 The block SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port clear  input  1  synchronous count-to-zero request.
REQ-006 The block SHALL have port load  input  1  synchronous parallel-load request.
REQ-007 The block SHALL have port load_val  input  WIDTH  value for load.
REQ-008 The block SHALL have port en  input  1  count enable.
REQ-009 The block SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 The block SHALL have port q  output  WIDTH  registered count value.
REQ-011 The block SHALL have port tc  output  1  combinational terminal count.
REQ-012 The block SHALL have port wrap  output  1  registered one-cycle wrap pulse.
REQ-013 The block SHALL have port load_err  output  1  registered one-cycle out-of-range-load pulse.

Function
REQ-014 Per rising clk edge, priority SHALL be reset > clear > load > en; lower-priority requests in the same cycle are ignored.
REQ-015 clear SHALL set q to 0 on the next edge, with wrap = 0.
REQ-016 load with load_val < MOD SHALL set q to load_val on the next edge, with load_err = 0.
REQ-017 load with load_val >= MOD SHALL set q to MOD-1 and pulse load_err for exactly one cycle.
REQ-018 en=1, up=1: q SHALL become q+1, or 0 when q == MOD-1.
REQ-019 en=1, up=0: q SHALL become q-1, or MOD-1 when q == 0.
REQ-020 en=0 with no higher-priority request SHALL hold q unchanged.
REQ-021 wrap SHALL be 1 in exactly the cycle following an enabled wrap transition (MOD-1 to 0 up, or 0 to MOD-1 down), and 0 otherwise, including after clear or load.
REQ-022 tc SHALL equal (up && q == MOD-1) || (!up && q == 0), independent of en.
REQ-023 Count latency SHALL be one cycle from en sampled high to the updated q.
REQ-024 Arithmetic SHALL be modulo MOD on WIDTH bits; q SHALL never exceed MOD-1.
REQ-025 Changing up between cycles SHALL take effect on the next enabled edge, with no extra step or skipped value.
REQ-026 When MOD == 2**WIDTH, wrap behaviour SHALL match natural binary overflow and underflow.
REQ-027 With WIDTH=1 and MOD=2, en=1 SHALL toggle q every cycle.

Reset
REQ-028 reset=1 at a rising clk edge SHALL force q=0, wrap=0 and load_err=0, overriding all other inputs.
REQ-029 reset asserted mid-count SHALL take effect on that edge; counting SHALL resume from 0 on the first edge after reset is released.
REQ-030 No output SHALL change except on a rising clk edge, apart from tc, which follows q and up.

Structure
REQ-031 Shared package counter_pkg SHALL hold constants DIR_UP=1 and DIR_DOWN=0 and the default WIDTH and MOD values.
REQ-032 Per-bit state SHALL be built from a sub-module tff_sync, a synchronous-reset toggle cell with toggle-enable and parallel-load inputs, instantiated WIDTH times; the modulus and wrap logic stays in mod_counter.
REQ-033 The parameter check MOD < 2 or MOD > 2**WIDTH SHALL stop elaboration.

Verification
REQ-034 WIDTH=4, MOD=10, up=1, en=1 for 12 cycles from reset -> q = 1..9,0,1,2; wrap high only in the cycle q=0; tc high while q=9.
REQ-035 WIDTH=4, MOD=10, load load_val=3, then up=0, en=1 for 5 cycles -> q = 3,2,1,0,9,8; wrap pulses with q=9.
REQ-036 WIDTH=4, MOD=10, load load_val=12 -> q=9 and load_err=1 for one cycle; next cycle load_err=0.
REQ-037 q=5, clear=1, load=1 (load_val=7) and en=1 in the same cycle -> q=0; then reset=1 with load=1 -> q=0, wrap=0.
REQ-038 WIDTH=3, MOD=8, up=1 from q=7, en toggled 1/0/1 -> q 0 (wrap=1), hold 0 (wrap=0), then 1.
REQ-039 WIDTH=1, MOD=2, en=1 for 6 cycles -> q toggles 1,0,1,0,1,0; wrap on each 0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the modulo counter: direction encoding and default geometry.
package counter_pkg;
  localparam logic            DIR_UP    = 1'b1;
  localparam logic            DIR_DOWN  = 1'b0;
  localparam int unsigned     DEF_WIDTH = 4;
  localparam longint unsigned DEF_MOD   = 16;
endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle of the modulo counter; master drives requests, slave is the counter.
interface mod_counter_if #(
  parameter int unsigned WIDTH = counter_pkg::DEF_WIDTH
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (output clear, load, load_val, en, up,
                  input  q, tc, wrap, load_err);
  modport slave  (input  clear, load, load_val, en, up,
                  output q, tc, wrap, load_err);
endinterface

// File: rtl/tff_sync.sv
// One count bit: synchronous-reset toggle flop with a parallel-load override.
module tff_sync (
  input  logic clk,
  input  logic rst_i,
  input  logic t_i,
  input  logic ld_i,
  input  logic d_i,
  output logic q_o
);
  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i)     q_d = d_i;
    else if (t_i) q_d = ~q_q;
  end

  always_ff @(posedge clk) begin
    if (rst_i) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/mod_counter.sv
// Up/down modulo-MOD counter with clear, clamped load, terminal count and wrap/load-error pulses.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH = DEF_WIDTH,
  parameter longint unsigned MOD   = DEF_MOD
) (
  input  logic          clk,
  input  logic          reset,
  mod_counter_if.slave  bus
);
  if (WIDTH < 1 || WIDTH > 32 || MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_param
    $fatal(1, "mod_counter: MOD must lie in 2..2**WIDTH and WIDTH in 1..32");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] tgl_mask;
  logic [WIDTH-1:0] ld_val;
  logic             ld;
  logic             tc;
  logic             oor;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  assign tc  = (bus.up == DIR_UP   && cnt == MAX_Q) ||
               (bus.up == DIR_DOWN && cnt == '0);
  assign oor = 64'(bus.load_val) >= MOD;

  // Ripple toggle enables: a bit flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic carry;
    carry    = 1'b1;
    tgl_mask = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      tgl_mask[i] = carry;
      carry       = carry & (bus.up ? cnt[i] : ~cnt[i]);
    end
  end

  // Terminal-count steps are done as a load so non-power-of-two moduli wrap correctly.
  always_comb begin
    ld         = 1'b0;
    ld_val     = '0;
    tgl        = '0;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.clear) begin
      ld = 1'b1;
    end else if (bus.load) begin
      ld = 1'b1;
      if (oor) begin
        ld_val     = MAX_Q;
        load_err_d = 1'b1;
      end else begin
        ld_val = bus.load_val;
      end
    end else if (bus.en) begin
      if (tc) begin
        ld     = 1'b1;
        ld_val = bus.up ? '0 : MAX_Q;
        wrap_d = 1'b1;
      end else begin
        tgl = tgl_mask;
      end
    end
  end

  tff_sync u_bit [WIDTH-1:0] (
    .clk   (clk),
    .rst_i (reset),
    .t_i   (tgl),
    .ld_i  (ld),
    .d_i   (ld_val),
    .q_o   (cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.q        = cnt;
  assign bus.tc       = tc;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;
endmodule
